// File: rtl/cbus_cpu_pkg.sv
// Shared types and constants for the 8-bit common-bus CPU.
//   opcode_t  : 4-bit instruction opcodes
//   step_t    : micro-step counter values T0..T8
//   bus_src_t : which source drives the shared bus in a step
//   alu_op_t  : operations understood by cbus_alu
//   *_LSB/_MSB: bit positions of the instruction fields
package cbus_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,  OP_LOADI = 4'd1,  OP_MOV = 4'd2,  OP_ADD = 4'd3,
    OP_SUB   = 4'd4,  OP_AND   = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_NOT   = 4'd8,  OP_SHL   = 4'd9,  OP_SHR = 4'd10, OP_INC = 4'd11,
    OP_DEC   = 4'd12, OP_JMP   = 4'd13, OP_JZ  = 4'd14, OP_RSVD = 4'd15
  } opcode_t;

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
    T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, T8 = 4'd8
  } step_t;

  // SRC_ALU is the G pass-through path: the ALU output driven straight onto the bus.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0, SRC_RD = 3'd1, SRC_RS = 3'd2, SRC_IMM = 3'd3,
    SRC_PC   = 3'd4, SRC_G  = 3'd5, SRC_ALU = 3'd6
  } bus_src_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOT = 4'd5, ALU_SHL = 4'd6, ALU_SHR = 4'd7,
    ALU_INC = 4'd8, ALU_DEC = 4'd9, ALU_PASS = 4'd10
  } alu_op_t;

  localparam int OPC_LSB = 32'd0;
  localparam int OPC_MSB = 32'd3;
  localparam int RD_LSB  = 32'd4;
  localparam int RD_MSB  = 32'd5;
  localparam int RS_LSB  = 32'd6;
  localparam int RS_MSB  = 32'd7;
  localparam int IMM_LSB = 32'd6;
  localparam int IMM_MSB = 32'd13;

  // Map an arithmetic/logic opcode to its ALU operation.
  function automatic alu_op_t to_alu_op(input opcode_t opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_INC:  return ALU_INC;
      OP_DEC:  return ALU_DEC;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cbus_alu.sv
// Combinational 8-bit ALU.
//   a, b   : operands (A and B latches)
//   op     : operation select
//   result : 8-bit wrap-around result
//   carry  : carry / borrow / shifted-out bit (0 for logic ops)
//   zero   : result == 0
module cbus_alu
  import cbus_cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  // Bit 8 of the 9-bit result carries C for every operation.
  logic [8:0] wide;

  // Operation select; subtraction borrow falls out of bit 8 of the 9-bit difference.
  always_comb begin
    wide = 9'd0;
    case (op)
      ALU_ADD:  wide = {1'b0, a} + {1'b0, b};
      ALU_SUB:  wide = {1'b0, a} - {1'b0, b};
      ALU_AND:  wide = {1'b0, a & b};
      ALU_OR:   wide = {1'b0, a | b};
      ALU_XOR:  wide = {1'b0, a ^ b};
      ALU_NOT:  wide = {1'b0, ~a};
      ALU_SHL:  wide = {a, 1'b0};
      ALU_SHR:  wide = {a[0], 1'b0, a[7:1]};
      ALU_INC:  wide = {1'b0, a} + 9'd1;
      ALU_DEC:  wide = {1'b0, a} - 9'd1;
      ALU_PASS: wide = {1'b0, a};
      default:  wide = 9'd0;
    endcase
  end

  assign result = wide[7:0];
  assign carry  = wide[8];
  assign zero   = (wide[7:0] == 8'd0);

endmodule

// File: rtl/eight_bit_common_bus_cpu.sv
// Multi-cycle 8-bit CPU where every transfer uses one shared 8-bit bus.
//   clock                : rising-edge clock
//   reset_n              : asynchronous active-low reset
//   instruction[13:0]    : instruction, held for 7 (LOADI) or 9 cycles
//   reg_val_or_pc        : debug select, 0 = PC, 1 = R[instruction[5:4]]
//   register_value_or_pc : combinational debug value
module eight_bit_common_bus_cpu
  import cbus_cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [13:0] instruction,
  input  logic        reg_val_or_pc,
  output logic [7:0]  register_value_or_pc
);

  step_t       step, step_next;
  logic [13:0] ir;
  logic [7:0]  pc, a, b, g, bus;
  logic [7:0]  regs [4];
  logic        z, c, skip;

  opcode_t     opc;
  logic [1:0]  rd, rs;
  logic [7:0]  imm;
  logic        is_loadi;

  bus_src_t    bus_src;
  alu_op_t     alu_op;
  logic [7:0]  alu_result;
  logic        alu_carry, alu_zero;
  logic [2:0]  tail;
  logic        ld_ir, ld_a, ld_b, ld_g, ld_pc_bus, ld_pc_imm;
  logic        ld_rd_bus, ld_rd_b, ld_flags, set_skip;

  assign opc      = opcode_t'(ir[OPC_MSB:OPC_LSB]);
  assign rd       = ir[RD_MSB:RD_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign imm      = ir[IMM_MSB:IMM_LSB];
  assign is_loadi = (opc == OP_LOADI);

  cbus_alu u_alu (
    .a      (a),
    .b      (b),
    .op     (alu_op),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Step decode: bus source, latch enables and next step.
  always_comb begin
    step_next = step_t'(step + 4'd1);
    bus_src   = SRC_NONE;
    alu_op    = ALU_PASS;
    tail      = 3'd0;
    ld_ir     = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_g      = 1'b0;
    ld_pc_bus = 1'b0;
    ld_pc_imm = 1'b0;
    ld_rd_bus = 1'b0;
    ld_rd_b   = 1'b0;
    ld_flags  = 1'b0;
    set_skip  = 1'b0;
    case (step)
      T0: ld_ir = 1'b1;
      T1: begin
        bus_src = is_loadi ? SRC_IMM : SRC_RD;
        ld_a    = 1'b1;
      end
      T2: begin
        // LOADI writes A back through the ALU pass path; others fetch B.
        bus_src   = is_loadi ? SRC_ALU : SRC_RS;
        ld_rd_bus = is_loadi;
        ld_b      = ~is_loadi;
      end
      T3: begin
        tail   = is_loadi ? 3'd1 : 3'd0;
        ld_g   = ~is_loadi;
        alu_op = to_alu_op(opc);
      end
      T4: begin
        tail = is_loadi ? 3'd2 : 3'd0;
        if (is_loadi) begin
          alu_op = ALU_PASS;
        end else begin
          // A and B are unchanged since T3, so the ALU still shows the flags for G.
          alu_op = to_alu_op(opc);
          case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_INC, OP_DEC: begin
              bus_src   = SRC_G;
              ld_rd_bus = 1'b1;
              ld_flags  = 1'b1;
            end
            OP_MOV: ld_rd_b = 1'b1;
            OP_JMP: begin
              ld_pc_imm = 1'b1;
              set_skip  = 1'b1;
            end
            OP_JZ: begin
              ld_pc_imm = z;
              set_skip  = z;
            end
            default: ld_rd_b = 1'b0;
          endcase
        end
      end
      T5:      tail = is_loadi ? 3'd3 : 3'd1;
      T6:      tail = is_loadi ? 3'd4 : 3'd2;
      T7:      tail = 3'd3;
      T8:      tail = 3'd4;
      default: step_next = T0;
    endcase
    // PC increment tail, suppressed after a taken jump.
    case (tail)
      3'd1: begin
        bus_src = skip ? SRC_NONE : SRC_PC;
        ld_a    = ~skip;
      end
      3'd2: begin
        alu_op = ALU_INC;
        ld_g   = ~skip;
      end
      3'd3: begin
        bus_src   = skip ? SRC_NONE : SRC_G;
        ld_pc_bus = ~skip;
      end
      3'd4:    step_next = T0;
      default: tail = 3'd0;
    endcase
  end

  // Shared bus multiplexer; undriven bus reads 0.
  always_comb begin
    case (bus_src)
      SRC_RD:  bus = regs[rd];
      SRC_RS:  bus = regs[rs];
      SRC_IMM: bus = imm;
      SRC_PC:  bus = pc;
      SRC_G:   bus = g;
      SRC_ALU: bus = alu_result;
      default: bus = 8'd0;
    endcase
  end

  // Architectural and micro-architectural state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step <= T0;
      ir   <= 14'd0;
      pc   <= 8'd0;
      a    <= 8'd0;
      b    <= 8'd0;
      g    <= 8'd0;
      z    <= 1'b0;
      c    <= 1'b0;
      skip <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
    end else begin
      step <= step_next;
      if (ld_ir) begin
        ir   <= instruction;
        skip <= 1'b0;
      end else if (set_skip) begin
        skip <= 1'b1;
      end
      if (ld_a) a <= bus;
      if (ld_b) b <= bus;
      if (ld_g) g <= alu_result;
      if (ld_pc_bus) pc <= bus;
      else if (ld_pc_imm) pc <= imm;
      if (ld_rd_bus) regs[rd] <= bus;
      else if (ld_rd_b) regs[rd] <= b;
      if (ld_flags) begin
        z <= alu_zero;
        c <= alu_carry;
      end
    end
  end

  assign register_value_or_pc = reg_val_or_pc ? regs[instruction[RD_MSB:RD_LSB]] : pc;

endmodule

// File: tb/tb_eight_bit_common_bus_cpu.sv
// Scoreboard bench for eight_bit_common_bus_cpu. The driver issues
// instructions back to back; at each instruction boundary it pushes the
// expected debug value (from an instruction-level model) into a queue, and
// the monitor compares queued entries against the DUT on the falling edge.
module tb_eight_bit_common_bus_cpu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] instruction = 14'd0;
  logic        reg_val_or_pc = 1'b0;
  logic [7:0]  register_value_or_pc;

  eight_bit_common_bus_cpu dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .instruction          (instruction),
    .reg_val_or_pc        (reg_val_or_pc),
    .register_value_or_pc (register_value_or_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Instruction-level reference state.
  int m_r[4];
  int m_pc;
  int m_z;
  int m_c;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0;
    m_z  = 0;
    m_c  = 0;
  endfunction

  function automatic void model_alu(input int rd, input int res, input int carry);
    m_r[rd] = res;
    m_z     = (res == 0) ? 1 : 0;
    m_c     = carry;
  endfunction

  function automatic void model_exec(input logic [13:0] ins);
    int op, rd, rs, imm, x, y, jumped;
    op  = int'(ins[3:0]);
    rd  = int'(ins[5:4]);
    rs  = int'(ins[7:6]);
    imm = int'(ins[13:6]);
    x   = m_r[rd];
    y   = m_r[rs];
    jumped = 0;
    case (op)
      1:  m_r[rd] = imm;
      2:  m_r[rd] = y;
      3:  model_alu(rd, (x + y) % 256, (x + y > 255) ? 1 : 0);
      4:  model_alu(rd, (x - y + 256) % 256, (x < y) ? 1 : 0);
      5:  model_alu(rd, x & y, 0);
      6:  model_alu(rd, x | y, 0);
      7:  model_alu(rd, x ^ y, 0);
      8:  model_alu(rd, 255 - x, 0);
      9:  model_alu(rd, (x * 2) % 256, (x >= 128) ? 1 : 0);
      10: model_alu(rd, x / 2, x % 2);
      11: model_alu(rd, (x + 1) % 256, (x == 255) ? 1 : 0);
      12: model_alu(rd, (x + 255) % 256, (x == 0) ? 1 : 0);
      13: begin m_pc = imm; jumped = 1; end
      14: if (m_z == 1) begin m_pc = imm; jumped = 1; end
      default: jumped = 0;
    endcase
    if (jumped == 0) m_pc = (m_pc + 1) % 256;
  endfunction

  function automatic void push_exp(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  // Drive one instruction for its full duration. The expected debug value
  // (state before the instruction executes) is queued for the monitor;
  // want >= 0 adds a hard-coded expectation for the same moment.
  task automatic issue(input logic [13:0] ins, input logic sel, input string name, input int want);
    instruction   = ins;
    reg_val_or_pc = sel;
    push_exp(name, sel ? m_r[int'(ins[5:4])] : m_pc);
    if (want >= 0) push_exp({name, "_const"}, want);
    model_exec(ins);
    repeat ((ins[3:0] == 4'd1) ? 7 : 9) @(posedge clock);
    #1;
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (int'(register_value_or_pc) != e.val) begin
        bad++;
        $display("FAIL %s: got %02h expected %02h", e.name, register_value_or_pc, e.val[7:0]);
      end
    end
  end

  // Stimulus: directed plan first, then randomized instructions.
  initial begin
    logic [13:0] ins;
    model_reset();
    reset_n = 1'b0;
    reg_val_or_pc = 1'b0;
    push_exp("reset_pc", 0);
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (register_value_or_pc !== 8'h00) begin
      bad++;
      $display("FAIL in_reset: got %02h expected 00", register_value_or_pc);
    end
    reset_n = 1'b1;

    issue(14'h0000, 1'b0, "nop_start", 0);
    issue(14'h0A91, 1'b0, "loadi_pc", 1);
    issue(14'h0010, 1'b1, "r1_2a", 8'h2A);
    issue(14'h3C01, 1'b0, "pc3", 3);
    issue(14'h0811, 1'b0, "pc4", 4);
    issue(14'h0043, 1'b0, "pc5", 5);
    issue(14'h0000, 1'b1, "add_r0", 8'h10);
    issue(14'h0161, 1'b0, "pc7", 7);
    issue(14'h00A4, 1'b1, "r2_05", 8'h05);
    issue(14'h102E, 1'b1, "sub_r2_zero", 0);
    issue(14'h0000, 1'b0, "jz_pc", 8'h40);
    issue(14'h3FCD, 1'b0, "pc41", 8'h41);
    issue(14'h0000, 1'b0, "jmp_ff", 8'hFF);
    issue(14'h1DF1, 1'b0, "pc_wrap", 0);
    issue(14'h0030, 1'b1, "r3_77", 8'h77);

    // Reset in the middle of an ADD R3,R3 (after its T0..T2 edges).
    instruction   = 14'h00F3;
    reg_val_or_pc = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (register_value_or_pc !== 8'h00) begin
      bad++;
      $display("FAIL midreset_immediate: got %02h expected 00", register_value_or_pc);
    end
    push_exp("midreset_r3", 0);
    @(negedge clock);
    #1;
    reg_val_or_pc = 1'b0;
    push_exp("midreset_pc", 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    issue(14'h0A91, 1'b1, "post_reset_r1", 0);
    issue(14'h0010, 1'b1, "post_reset_loadi", 8'h2A);
    issue(14'h0000, 1'b0, "post_reset_pc", 2);

    // Random instruction stream with random debug select.
    for (int i = 0; i < 250; i++) begin
      ins = 14'($urandom_range(0, 16383));
      issue(ins, 1'($urandom_range(0, 1)), "rand", -1);
    end
    issue(14'h0000, 1'b0, "final_pc", -1);
    total++;
    if (int'(register_value_or_pc) != m_pc) begin
      bad++;
      $display("FAIL final_pc_after: got %02h expected %02h", register_value_or_pc, m_pc[7:0]);
    end
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the stimulus uses fixed cycle counts, so this only guards the simulator.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
